adc_result_fifo: RTL

- Sits directly downstream of the multi-slope ADC sequencer and upstream of the SPI register bank.
- Captures each completed conversion's count_up/count_down/count_rundown triple into a small FIFO, so results are not overwritten while the MCU is reading them.
- Presents the oldest entry to the register bank, and drives the active-low interrupt line with a re-arming edge for each pending result.
- Accepts an asynchronous pop request from the SPI chip-select domain.

---
 rtl/adc_pkg.sv | 24 ++
 rtl/sync_rise_pulse.sv | 28 ++
 rtl/adc_result_fifo.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared types for the multi-slope ADC datapath: count width, result triple layout,
// interrupt FSM states and a saturating counter helper.
package adc_pkg;

    parameter int unsigned AdcCountW = 24;

    // Packed as {up, down, rundown}; sequencer and register bank use the same layout.
    typedef struct packed {
        logic [AdcCountW-1:0] up;
        logic [AdcCountW-1:0] down;
        logic [AdcCountW-1:0] rundown;
    } adc_result_t;

    typedef enum logic [1:0] {
        IntIdle   = 2'd0,
        IntAssert = 2'd1,
        IntGap    = 2'd2
    } int_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_rise_pulse.sv
// Two-flop synchroniser followed by a rising-edge detector; emits a one-cycle pulse
// in the clk domain for each rising edge of the asynchronous input.
module sync_rise_pulse (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/adc_result_fifo.sv
// Result FIFO between the ADC sequencer and the SPI register bank: buffers conversion
// triples, exposes the oldest one and drives a re-arming active-low interrupt.
module adc_result_fifo
    import adc_pkg::*;
#(
    parameter int unsigned W       = AdcCountW,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned INT_GAP = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    done,
    input  logic [W-1:0]            in_up,
    input  logic [W-1:0]            in_down,
    input  logic [W-1:0]            in_rundown,
    input  logic                    pop_req_async,
    input  logic                    clr_ovf_async,
    output logic [W-1:0]            head_up,
    output logic [W-1:0]            head_down,
    output logic [W-1:0]            head_rundown,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic [7:0]              drop_count,
    output logic                    int_n
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned ResW = 3 * W;
    localparam int unsigned GapW = $clog2(INT_GAP + 1);
    localparam logic [LvlW-1:0] FullLvl = LvlW'(DEPTH);

    logic pop;
    logic clr;

    sync_rise_pulse u_pop_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (pop_req_async),
        .pulse    (pop)
    );

    sync_rise_pulse u_clr_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (clr_ovf_async),
        .pulse    (clr)
    );

    logic [ResW-1:0] mem_q [DEPTH];
    logic [ResW-1:0] in_data;
    logic [ResW-1:0] head_q, head_d;
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      drops_q, drops_d;
    int_state_e      state_q, state_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            int_n_q;

    logic empty;
    logic full;
    logic do_pop;
    logic do_push;
    logic drop;

    assign in_data = {in_up, in_down, in_rundown};

    // Push and pop both judged against the pre-cycle level; a pop makes room for a push.
    always_comb begin
        empty   = (level_q == '0);
        full    = (level_q == FullLvl);
        do_pop  = pop && !empty;
        do_push = done && (!full || do_pop);
        drop    = done && full && !do_pop;

        wptr_d  = do_push ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + PtrW'(1) : rptr_q;
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LvlW'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - LvlW'(1);
        end

        // Forward the incoming triple when it becomes the head in the same cycle.
        head_d = head_q;
        if (level_d != '0) begin
            head_d = (do_push && (rptr_d == wptr_q)) ? in_data : mem_q[rptr_d];
        end
    end

    always_comb begin
        ovf_d   = ovf_q;
        drops_d = drops_q;
        if (drop) begin
            ovf_d   = 1'b1;
            drops_d = clr ? 8'd1 : sat_inc8(drops_q);
        end else if (clr) begin
            ovf_d   = 1'b0;
            drops_d = 8'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        unique case (state_q)
            IntIdle: begin
                if (!empty) state_d = IntAssert;
            end
            IntAssert: begin
                if (do_pop) begin
                    if (level_d != '0) begin
                        state_d = IntGap;
                        gap_d   = GapW'(INT_GAP - 1);
                    end else begin
                        state_d = IntIdle;
                    end
                end
            end
            IntGap: begin
                if (gap_q == '0) begin
                    state_d = empty ? IntIdle : IntAssert;
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            default: state_d = IntIdle;
        endcase
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[wptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            head_q  <= '0;
            ovf_q   <= 1'b0;
            drops_q <= 8'd0;
            state_q <= IntIdle;
            gap_q   <= '0;
            int_n_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            head_q  <= head_d;
            ovf_q   <= ovf_d;
            drops_q <= drops_d;
            state_q <= state_d;
            gap_q   <= gap_d;
            int_n_q <= (state_d != IntAssert);
        end
    end

    assign head_up      = head_q[3*W-1 -: W];
    assign head_down    = head_q[2*W-1 -: W];
    assign head_rundown = head_q[W-1:0];
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign drop_count   = drops_q;
    assign int_n        = int_n_q;

endmodule
